// File: rtl/cs_avg4_stage.sv
// Carry-save resolve, divide-by-4 average and 5-bit saturate, 2-stage valid/ready pipe.
// Optional build macro CS_AVG_ROUND_EN selects round-half-up instead of truncation.
module cs_avg4_stage #(
    parameter int IN_W   = 7,
    parameter int OUT_W  = 5,
    parameter int SHIFT  = 2,
    parameter int LINE_W = 640,
    parameter int COL_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  cs_a,
    input  logic [IN_W-1:0]  cs_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] pix,
    output logic [COL_W-1:0] col,
    output logic             eol
);

    localparam logic [IN_W+1:0]  MAXV = (IN_W+2)'((1 << OUT_W) - 1);
    localparam logic [COL_W-1:0] LAST = COL_W'(LINE_W - 1);

    logic             s1_v_q, s1_v_d;
    logic [IN_W:0]    sum_q, sum_d;
    logic             s2_v_q, s2_v_d;
    logic [OUT_W-1:0] pix_q, pix_d;
    logic [COL_W-1:0] col_q, col_d;

    logic             adv1, adv2, out_hs;
    logic [IN_W+1:0]  q_w;
    logic [OUT_W-1:0] sat_w;

    assign adv2     = s1_v_q && (!s2_v_q || out_ready);
    assign in_ready = !s1_v_q || adv2;
    assign adv1     = in_valid && in_ready;
    assign out_hs   = s2_v_q && out_ready;

`ifdef CS_AVG_ROUND_EN
    localparam logic [IN_W+1:0] RND = (IN_W+2)'(1 << (SHIFT - 1));
    assign q_w = ({1'b0, sum_q} + RND) >> SHIFT;
`else
    assign q_w = {1'b0, sum_q} >> SHIFT;
`endif

    assign sat_w = (q_w > MAXV) ? {OUT_W{1'b1}} : q_w[OUT_W-1:0];

    always_comb begin
        s1_v_d = s1_v_q;
        sum_d  = sum_q;
        s2_v_d = s2_v_q;
        pix_d  = pix_q;
        col_d  = col_q;

        if (adv1) begin
            sum_d = {1'b0, cs_a} + {1'b0, cs_b};
        end
        if (adv1) begin
            s1_v_d = 1'b1;
        end else if (adv2) begin
            s1_v_d = 1'b0;
        end

        if (adv2) begin
            s2_v_d = 1'b1;
            pix_d  = sat_w;
        end else if (out_hs) begin
            s2_v_d = 1'b0;
        end

        // col names the pixel currently held in S2, so it steps only on handshake
        if (out_hs) begin
            col_d = (col_q == LAST) ? '0 : col_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            sum_q  <= '0;
            s2_v_q <= 1'b0;
            pix_q  <= '0;
            col_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            sum_q  <= sum_d;
            s2_v_q <= s2_v_d;
            pix_q  <= pix_d;
            col_q  <= col_d;
        end
    end

    assign out_valid = s2_v_q;
    assign pix       = pix_q;
    assign col       = col_q;
    assign eol       = s2_v_q && (col_q == LAST);

endmodule

// File: tb/tb_cs_avg4_stage.sv
// Directed bench for cs_avg4_stage: default line and a LINE_W=4 copy on shared inputs.
// Expected pixels follow CS_AVG_ROUND_EN when the bench is built with it.
module tb_cs_avg4_stage;

`ifdef CS_AVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] cs_a = '0;
    logic [6:0] cs_b = '0;

    logic       in_ready, out_valid, eol;
    logic [4:0] pix;
    logic [9:0] col;
    logic       in_ready4, out_valid4, eol4;
    logic [4:0] pix4;
    logic [1:0] col4;

    int n_cmp = 0;
    int n_bad = 0;
    int nout  = 0;
    int idx, sent, got;
    bit acc;

    cs_avg4_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .cs_a(cs_a), .cs_b(cs_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .pix(pix), .col(col), .eol(eol)
    );

    cs_avg4_stage #(.LINE_W(4), .COL_W(2)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .cs_a(cs_a), .cs_b(cs_b),
        .out_valid(out_valid4), .out_ready(out_ready),
        .pix(pix4), .col(col4), .eol(eol4)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got_v, input int exp_v);
        n_cmp++;
        if (got_v != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one output beat about to hand off: check both copies, then advance column model
    task automatic chk_out(input string tag, input int ep);
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_pix"}, pix, ep);
        chk({tag, "_col"}, col, nout % 640);
        chk({tag, "_eol"}, eol, ((nout % 640) == 639) ? 1 : 0);
        chk({tag, "_pix4"}, pix4, ep);
        chk({tag, "_col4"}, col4, nout % 4);
        chk({tag, "_eol4"}, eol4, ((nout % 4) == 3) ? 1 : 0);
        nout++;
    endtask

    task automatic send1(input int a, input int b, input int ep, input string tag);
        in_valid  = 1'b1;
        cs_a      = 7'(a);
        cs_b      = 7'(b);
        out_ready = 1'b1;
        #1;
        chk({tag, "_ir"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, out_valid, 0);
        tick();
        #1;
        chk_out(tag, ep);
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_pix", pix, 0);
        chk("rst_col", col, 0);
        chk("rst_eol", eol, 0);
        chk("rst_ir", in_ready, 1);

        send1(60, 62, RND ? 31 : 30, "avg60_62");
        send1(1, 1, RND ? 1 : 0, "avg1_1");
        send1(0, 0, 0, "avg0_0");
        send1(127, 127, 31, "sat254");

        // stall: four beats offered while the consumer refuses for 5 cycles
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            cs_a = 7'(4 * (idx + 1));
            cs_b = '0;
            #1;
            chk("stall_ir", in_ready, (c < 2) ? 1 : 0);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (c >= 1) begin
                chk("stall_ov", out_valid, 1);
                chk("stall_pix", pix, 1);
            end
        end
        chk("stall_acc", idx, 2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = (idx < 4);
            cs_a = 7'(4 * (idx + 1));
            #1;
            chk_out("drain", k + 1);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("drain_acc", idx, 4);
        in_valid = 1'b0;
        #1;
        chk("drain_empty", out_valid, 0);

        // six-pixel stream: LINE_W=4 copy wraps columns 0,1,2,3,0,1
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = (sent < 6);
            cs_a = 7'(4 * (sent + 1));
            #1;
            if (out_valid) begin
                chk_out("stream", got + 1);
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        chk("stream_cnt", got, 6);

        // fill both stages, then reset with the consumer ready
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cs_a = 7'd40;
        tick();
        cs_a = 7'd44;
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_ov", out_valid, 1);
        chk("full_ir", in_ready, 0);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_col", col, 0);
        chk("mrst_col4", col4, 0);
        chk("mrst_ir", in_ready, 1);
        chk("mrst_pix", pix, 0);
        nout = 0;
        send1(8, 0, 2, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
